// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// One full-subtractor cell is reused every cycle. A registered borrow links
// consecutive bits. A start/busy/done handshake frames each operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter needs at least one bit, even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  logic             bit_x, bit_y, bit_d, bit_bout;
  logic             last_bit;
  logic [WIDTH-1:0] res_shifted;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  assign bit_x    = a_sh_reg[0];
  assign bit_y    = b_sh_reg[0];
  assign bit_d    = bit_x ^ bit_y ^ borrow_reg;
  assign bit_bout = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & borrow_reg);
  assign last_bit = (cnt_reg == LAST_BIT);

  // Result register shifted right with the new difference bit entering the
  // MSB; after WIDTH shifts the first (LSB) bit has reached position 0.
  assign res_shifted[WIDTH-1] = bit_d;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
      assign res_shifted[gi] = res_reg[gi+1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, process one bit per SHIFT cycle, and
  // publish the result only on the completion edge so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_reg    <= res_shifted;
          borrow_reg <= bit_bout;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_bit) begin
            diff       <= res_shifted;
            borrow_out <= bit_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow_out;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge (the accept edge).
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
  endtask

  // Called right after the accept edge; returns cycles until done, -1 on timeout.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      fails++;
      $display("FAIL reset_release: got busy=%b done=%b diff=%h borrow=%b, want all 0",
               busy, done, diff, borrow_out);
    end
    // Leave a nonzero result behind so the asynchronous clear is observable.
    start_op(8'h01, 8'h02);
    wait_done(c);
    tests++;
    if (diff !== 8'hFF || borrow_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_preop: got diff=%h borrow=%b, want FF 1", diff, borrow_out);
    end
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-cycle: busy=%b done=%b diff=%h borrow=%b",
             busy, done, diff, borrow_out);
    tests++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      fails++;
      $display("FAIL reset_async: got busy=%b done=%b diff=%h borrow=%b, want all 0",
               busy, done, diff, borrow_out);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle[%0d]: got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    start_op(8'h5A, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL basic_busy[%0d]: got busy=%b done=%b, want 1 0", i, busy, done);
      end
      tick();
    end
    $display("[TB] basic 5A-3C: done=%b diff=%h borrow=%b", done, diff, borrow_out);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h1E || borrow_out !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got done=%b busy=%b diff=%h borrow=%b, want 1 0 1E 0",
               done, busy, diff, borrow_out);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse: got done=%b one cycle later, want 0", done);
    end
    repeat (3) tick();
    tests++;
    if (diff !== 8'h1E || borrow_out !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: got diff=%h borrow=%b busy=%b, want 1E 0 0",
               diff, borrow_out, busy);
    end
  endtask

  task automatic test_underflow();
    int c;
    start_op(8'h00, 8'h01);
    wait_done(c);
    $display("[TB] underflow 00-01: cycles=%0d diff=%h borrow=%b", c, diff, borrow_out);
    tests++;
    if (c !== 8 || diff !== 8'hFF || borrow_out !== 1'b1) begin
      fails++;
      $display("FAIL underflow_00_01: got cycles=%0d diff=%h borrow=%b, want 8 FF 1",
               c, diff, borrow_out);
    end
    tick();
    start_op(8'h80, 8'h80);
    wait_done(c);
    $display("[TB] equal 80-80: cycles=%0d diff=%h borrow=%b", c, diff, borrow_out);
    tests++;
    if (c !== 8 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      fails++;
      $display("FAIL equal_80_80: got cycles=%0d diff=%h borrow=%b, want 8 00 0",
               c, diff, borrow_out);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int n_done;
    int busy_after;
    n_done     = 0;
    busy_after = 0;
    start_op(8'h10, 8'h01);
    tick();
    tick();
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        n_done++;
        $display("[TB] start-while-busy done: diff=%h borrow=%b", diff, borrow_out);
        tests++;
        if (diff !== 8'h0F || borrow_out !== 1'b0) begin
          fails++;
          $display("FAIL busy_ignore_result: got diff=%h borrow=%b, want 0F 0",
                   diff, borrow_out);
        end
      end else if (n_done > 0 && busy === 1'b1) begin
        busy_after++;
      end
      tick();
    end
    tests++;
    if (n_done !== 1 || busy_after !== 0) begin
      fails++;
      $display("FAIL busy_ignore_count: got dones=%0d busy_after=%0d, want 1 0",
               n_done, busy_after);
    end
  endtask

  task automatic test_reset_mid_op();
    int c;
    int n_done;
    n_done = 0;
    start_op(8'h77, 8'h11);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-op: busy=%b done=%b diff=%h borrow=%b",
             busy, done, diff, borrow_out);
    tests++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      fails++;
      $display("FAIL midop_reset: got busy=%b done=%b diff=%h borrow=%b, want all 0",
               busy, done, diff, borrow_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    tests++;
    if (n_done !== 0) begin
      fails++;
      $display("FAIL midop_no_done: got %0d done pulses, want 0", n_done);
    end
    start_op(8'h03, 8'h05);
    wait_done(c);
    $display("[TB] after reset 03-05: cycles=%0d diff=%h borrow=%b", c, diff, borrow_out);
    tests++;
    if (c !== 8 || diff !== 8'hFE || borrow_out !== 1'b1) begin
      fails++;
      $display("FAIL midop_next_op: got cycles=%0d diff=%h borrow=%b, want 8 FE 1",
               c, diff, borrow_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int unstable;
    unstable = 0;
    a     = 8'hC8;
    b     = 8'h64;
    start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (done === 1'b1) begin
        done_at.push_back(i);
        tests++;
        if (diff !== 8'h64 || borrow_out !== 1'b0) begin
          fails++;
          $display("FAIL b2b_result[%0d]: got diff=%h borrow=%b, want 64 0",
                   done_at.size(), diff, borrow_out);
        end
      end else if (done_at.size() > 0 && busy === 1'b1 && diff !== 8'h64) begin
        unstable++;
      end
    end
    start = 1'b0;
    tests++;
    if (done_at.size() !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", done_at.size());
    end else begin
      $display("[TB] back-to-back dones at cycles %0d %0d %0d",
               done_at[0], done_at[1], done_at[2]);
      tests++;
      if (done_at[1] - done_at[0] !== 10 || done_at[2] - done_at[1] !== 10) begin
        fails++;
        $display("FAIL b2b_period: got intervals %0d %0d, want 10 10",
                 done_at[1] - done_at[0], done_at[2] - done_at[1]);
      end
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("FAIL b2b_hold: got %0d SHIFT cycles with diff != 64, want 0", unstable);
    end
    repeat (12) tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_underflow();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
